// File: rtl/spi_egress_framer_pkg.sv
// spi_egress_framer_pkg: shared FSM state type and default framing bytes.
// Contents: state_t (IDLE, HEADER, DATA), DEF_HEADER_BYTE, DEF_IDLE_BYTE.
package spi_egress_framer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

    localparam logic [7:0] DEF_HEADER_BYTE = 8'hA5;
    localparam logic [7:0] DEF_IDLE_BYTE   = 8'h3D;

endpackage

// File: rtl/spi_egress_framer_if.sv
// spi_egress_framer_if: word-in / byte-out stream bundle of the framer.
// Signals: s_axis_tdata[31:0], s_axis_tvalid, s_axis_tready, s_axis_tlast (word side);
//          m_axis_tdata[7:0], m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser[7:0] (byte side).
// Modports: master = environment (feeds words, sinks bytes); slave = framer.
interface spi_egress_framer_if;

    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tuser;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

endinterface

// File: rtl/spi_egress_byte_sel.sv
// spi_egress_byte_sel: combinational pick of one byte from a 32-bit word.
// Ports: word[31:0] in, byte_idx[1:0] in (transmit order), byte_out[7:0] out.
// MSB_FIRST=1 sends [31:24] as byte 0, MSB_FIRST=0 sends [7:0] as byte 0.
module spi_egress_byte_sel #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [31:0] word,
    input  logic [1:0]  byte_idx,
    output logic [7:0]  byte_out
);

    logic [1:0] lane;

    assign lane     = MSB_FIRST ? ~byte_idx : byte_idx;
    assign byte_out = word[{lane, 3'b000} +: 8];

endmodule

// File: rtl/spi_egress_framer.sv
// spi_egress_framer: splits 32-bit words into a byte stream framed by a header byte.
// Ports: clk, resn (async active-low), bus (spi_egress_framer_if.slave),
//        flush in (drops held word and open frame), frame_active out.
// Optional SPI_EGRESS_FRAMER_STATS_EN adds frame_count[15:0] and split_count[15:0] outputs.
module spi_egress_framer
    import spi_egress_framer_pkg::*;
#(
    parameter bit         MSB_FIRST   = 1'b1,
    parameter int         MTU_WORDS   = 16,
    parameter logic [7:0] HEADER_BYTE = DEF_HEADER_BYTE,
    parameter logic [7:0] IDLE_BYTE   = DEF_IDLE_BYTE
) (
    input  logic                clk,
    input  logic                resn,
    spi_egress_framer_if.slave  bus,
    input  logic                flush,
    output logic                frame_active
`ifdef SPI_EGRESS_FRAMER_STATS_EN
    ,
    output logic [15:0]         frame_count,
    output logic [15:0]         split_count
`endif
);

    state_t      state;
    logic [1:0]  byte_idx;
    logic [1:0]  nxt_idx;
    logic [7:0]  word_cnt;
    logic        frame_open;
    logic [31:0] word_q;
    logic        last_q;
    logic [31:0] sel_word;
    logic [7:0]  sel_byte;
    logic        at_mtu;
    logic        ends_frame;
    logic        s_tready;
    logic        m_tvalid;
    logic        m_tlast;
    logic [7:0]  m_tdata;
`ifdef SPI_EGRESS_FRAMER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] split_cnt_q;

    assign frame_count = frame_cnt_q;
    assign split_count = split_cnt_q;
`endif

    assign bus.s_axis_tready = s_tready;
    assign bus.m_axis_tvalid = m_tvalid;
    assign bus.m_axis_tlast  = m_tlast;
    assign bus.m_axis_tdata  = m_tdata;
    assign bus.m_axis_tuser  = IDLE_BYTE;
    assign frame_active      = frame_open | (state == HEADER);

    assign at_mtu     = word_cnt == 8'(MTU_WORDS - 1);
    assign ends_frame = last_q | at_mtu;

    // The byte to present next is preloaded into m_tdata, so the selector looks one step ahead:
    // in IDLE/HEADER that is byte 0 (of the incoming or held word), in DATA it is byte_idx+1.
    assign sel_word = (state == IDLE) ? bus.s_axis_tdata : word_q;
    assign nxt_idx  = (state == DATA) ? byte_idx + 2'd1 : 2'd0;

    spi_egress_byte_sel #(.MSB_FIRST(MSB_FIRST)) u_byte_sel (
        .word     (sel_word),
        .byte_idx (nxt_idx),
        .byte_out (sel_byte)
    );

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state      <= IDLE;
            byte_idx   <= 2'd0;
            word_cnt   <= 8'd0;
            frame_open <= 1'b0;
            word_q     <= 32'd0;
            last_q     <= 1'b0;
            s_tready   <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_tdata    <= 8'h00;
`ifdef SPI_EGRESS_FRAMER_STATS_EN
            frame_cnt_q <= 16'd0;
            split_cnt_q <= 16'd0;
`endif
        end else if (flush) begin
            state      <= IDLE;
            byte_idx   <= 2'd0;
            word_cnt   <= 8'd0;
            frame_open <= 1'b0;
            s_tready   <= 1'b1;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.s_axis_tvalid && s_tready) begin
                        word_q   <= bus.s_axis_tdata;
                        last_q   <= bus.s_axis_tlast;
                        s_tready <= 1'b0;
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b0;
                        byte_idx <= 2'd0;
                        state    <= frame_open ? DATA : HEADER;
                        m_tdata  <= frame_open ? sel_byte : HEADER_BYTE;
                    end else begin
                        s_tready <= 1'b1;
                    end
                end
                HEADER: begin
                    if (bus.m_axis_tready) begin
                        frame_open <= 1'b1;
                        state      <= DATA;
                        m_tdata    <= sel_byte;
                    end
                end
                DATA: begin
                    if (bus.m_axis_tready) begin
                        byte_idx <= nxt_idx;
                        m_tdata  <= sel_byte;
                        m_tlast  <= (nxt_idx == 2'd3) && ends_frame;
                        if (byte_idx == 2'd3) begin
                            state    <= IDLE;
                            m_tvalid <= 1'b0;
                            s_tready <= 1'b1;
                            word_cnt <= ends_frame ? 8'd0 : word_cnt + 8'd1;
                            if (ends_frame)
                                frame_open <= 1'b0;
`ifdef SPI_EGRESS_FRAMER_STATS_EN
                            if (ends_frame)
                                frame_cnt_q <= frame_cnt_q + 16'd1;
                            if (at_mtu && !last_q)
                                split_cnt_q <= split_cnt_q + 16'd1;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
